matrix_frame_sequencer: RTL and testbench



---
 rtl/matrix_pkg.sv | 20 ++
 rtl/seq_addr_gen.sv | 48 ++++
 rtl/matrix_frame_sequencer.sv | 176 +++++++++++++++++
 tb/tb_matrix_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: sequencer state encoding and default geometry of the 16x8 RGB SPI LED matrix,
// shared by matrix_frame_sequencer, output_module and the top level.
package matrix_pkg;
    localparam int CHANNEL_NUMBER   = 3;
    localparam int SPI_SIZE         = 8;
    localparam int COLUMNS          = 16;
    localparam int BYTES_PER_COLUMN = 24;
    localparam int ADDR_W           = 9;

    typedef enum logic [2:0] {
        IDLE,
        IMG_START,
        WAIT_RDY,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_ACC,
        COL_END
    } seq_state_t;
endpackage

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: byte/column counters of the frame walk and the registered buffer read address.
module seq_addr_gen #(
    parameter int COLUMNS          = matrix_pkg::COLUMNS,
    parameter int BYTES_PER_COLUMN = matrix_pkg::BYTES_PER_COLUMN,
    parameter int ADDR_W           = matrix_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_clr,
    input  logic              byte_inc,
    input  logic              col_inc,
    output logic              last_byte,
    output logic              last_col,
    output logic [ADDR_W-1:0] rd_addr
);
    import matrix_pkg::*;

    localparam int BW = $clog2(BYTES_PER_COLUMN);
    localparam int CW = $clog2(COLUMNS);

    logic [BW-1:0]     byte_q, byte_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    // rd_addr is built from the next counter values so it is already valid in the FETCH cycle
    always_comb begin
        byte_d = clr || byte_clr ? '0 : byte_inc ? byte_q + BW'(1) : byte_q;
        col_d  = clr ? '0 : col_inc ? col_q + CW'(1) : col_q;
        rd_addr_d = ADDR_W'(col_d) * ADDR_W'(BYTES_PER_COLUMN) + ADDR_W'(byte_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q    <= '0;
            col_q     <= '0;
            rd_addr_q <= '0;
        end else begin
            byte_q    <= byte_d;
            col_q     <= col_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign last_byte = byte_q == BW'(BYTES_PER_COLUMN - 1);
    assign last_col  = col_q == CW'(COLUMNS - 1);
    assign rd_addr   = rd_addr_q;
endmodule

// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer: walks one buffered frame per frame_valid and paces output_module on tx_finish.
// MATRIX_SEQ_REPEAT_EN: replay the buffer continuously while frame_valid is low.
module matrix_frame_sequencer #(
    parameter int CHANNEL_NUMBER   = matrix_pkg::CHANNEL_NUMBER,
    parameter int SPI_SIZE         = matrix_pkg::SPI_SIZE,
    parameter int COLUMNS          = matrix_pkg::COLUMNS,
    parameter int BYTES_PER_COLUMN = matrix_pkg::BYTES_PER_COLUMN,
    parameter int ADDR_W           = matrix_pkg::ADDR_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_valid,
    output logic                               frame_ack,
    output logic                               rd_en,
    output logic [ADDR_W-1:0]                  rd_addr,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out,
    output logic                               new_image,
    output logic                               new_column,
    output logic                               next_data,
    output logic                               extra_bit,
    input  logic                               tx_finish,
    output logic                               busy,
    output logic [15:0]                        frame_count
);
    import matrix_pkg::*;

    seq_state_t                         state_q, state_d;
    logic                               new_image_q, new_image_d;
    logic                               new_column_q, new_column_d;
    logic                               next_data_q, next_data_d;
    logic                               frame_ack_q, frame_ack_d;
    logic                               rd_en_q, rd_en_d;
    logic                               extra_bit_q, extra_bit_d;
    logic                               busy_q, busy_d;
    logic                               acc_q, acc_d;
    logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out_q, data_out_d;
    logic [15:0]                        frame_count_q, frame_count_d;
    logic                               cnt_clr, byte_clr, byte_inc, col_inc;
    logic                               last_byte, last_col;

    seq_addr_gen #(
        .COLUMNS         (COLUMNS),
        .BYTES_PER_COLUMN(BYTES_PER_COLUMN),
        .ADDR_W          (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .byte_clr (byte_clr),
        .byte_inc (byte_inc),
        .col_inc  (col_inc),
        .last_byte(last_byte),
        .last_col (last_col),
        .rd_addr  (rd_addr)
    );

    always_comb begin
        state_d       = state_q;
        new_image_d   = 1'b0;
        new_column_d  = 1'b0;
        next_data_d   = 1'b0;
        frame_ack_d   = 1'b0;
        rd_en_d       = 1'b0;
        extra_bit_d   = extra_bit_q;
        acc_d         = acc_q;
        data_out_d    = data_out_q;
        frame_count_d = frame_count_q;
        cnt_clr       = 1'b0;
        byte_clr      = 1'b0;
        byte_inc      = 1'b0;
        col_inc       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (frame_valid) begin
                    state_d     = IMG_START;
                    new_image_d = 1'b1;
                end
            end
            IMG_START: begin
                // a replayed frame lingers one cycle so new_image never lands on frame_ack
                if (frame_ack_q) new_image_d = 1'b1;
                else state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (tx_finish) begin
                    state_d = FETCH;
                    rd_en_d = 1'b1;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                data_out_d  = rd_data;
                extra_bit_d = last_byte;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (tx_finish) begin
                    next_data_d = 1'b1;
                    acc_d       = 1'b0;
                    state_d     = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                // tx_finish must fall (byte taken) before its rise counts as done
                if (!tx_finish) acc_d = 1'b1;
                else if (acc_q) begin
                    if (last_byte) state_d = COL_END;
                    else begin
                        byte_inc = 1'b1;
                        rd_en_d  = 1'b1;
                        state_d  = FETCH;
                    end
                end
            end
            COL_END: begin
                byte_clr = 1'b1;
                if (!last_col) begin
                    new_column_d = 1'b1;
                    col_inc      = 1'b1;
                    state_d      = WAIT_RDY;
                end else begin
                    frame_ack_d   = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    cnt_clr       = 1'b1;
`ifdef MATRIX_SEQ_REPEAT_EN
                    state_d       = frame_valid ? IDLE : IMG_START;
`else
                    state_d       = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            new_image_q   <= 1'b0;
            new_column_q  <= 1'b0;
            next_data_q   <= 1'b0;
            frame_ack_q   <= 1'b0;
            rd_en_q       <= 1'b0;
            extra_bit_q   <= 1'b0;
            busy_q        <= 1'b0;
            acc_q         <= 1'b0;
            data_out_q    <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            new_image_q   <= new_image_d;
            new_column_q  <= new_column_d;
            next_data_q   <= next_data_d;
            frame_ack_q   <= frame_ack_d;
            rd_en_q       <= rd_en_d;
            extra_bit_q   <= extra_bit_d;
            busy_q        <= busy_d;
            acc_q         <= acc_d;
            data_out_q    <= data_out_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign new_image   = new_image_q;
    assign new_column  = new_column_q;
    assign next_data   = next_data_q;
    assign frame_ack   = frame_ack_q;
    assign rd_en       = rd_en_q;
    assign extra_bit   = extra_bit_q;
    assign busy        = busy_q;
    assign data_out    = data_out_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// tb_matrix_frame_sequencer: frame scenarios from a table plus hand sequences for latency, reset, stall and wrap,
// checked against a frame-walk model of addresses, data and pulse counts.
module tb_matrix_frame_sequencer;
    localparam int CH     = 3;
    localparam int SW     = 8;
    localparam int COLS   = 16;
    localparam int BPC    = 24;
    localparam int AW     = 9;
    localparam int NBYTES = COLS * BPC;

    typedef struct {
        int lowlen;
        int drop_at;
        int exp_nd;
        int exp_nc;
        int exp_ni;
        int exp_ack;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_valid = 1'b0;
    logic          frame_ack, rd_en, new_image, new_column, next_data, extra_bit, busy, tx_finish;
    logic [AW-1:0] rd_addr;
    logic [CH*SW-1:0] rd_data = '0;
    logic [CH*SW-1:0] data_out;
    logic [15:0]   frame_count;
    logic [15:0]   exp_fc = '0;

    int checks = 0;
    int errors = 0;
    int lowlen = 4;
    bit hold_low = 1'b0;
    bit no_low = 1'b0;
    int low_cnt = 0;
    int k_rd = 0, k_nd = 0;
    int tot_nd = 0, tot_nc = 0, tot_ni = 0, tot_ack = 0;
    vec_t vecs[4];

    matrix_frame_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .data_out   (data_out),
        .new_image  (new_image),
        .new_column (new_column),
        .next_data  (next_data),
        .extra_bit  (extra_bit),
        .tx_finish  (tx_finish),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [CH*SW-1:0] exp_data(input int k);
        logic [CH*SW-1:0] e;
        for (int i = 0; i < CH; i++) e[i*SW +: SW] = SW'(k + i);
        return e;
    endfunction

    function automatic logic [63:0] all_outs();
        return {rd_en, new_image, new_column, next_data, frame_ack, extra_bit, busy, rd_addr, data_out, frame_count};
    endfunction

    // synchronous buffer: channel i holds addr+i
    always @(posedge clk)
        if (rd_en)
            for (int i = 0; i < CH; i++) rd_data[i*SW +: SW] <= SW'(int'(rd_addr) + i);

    // output_module stand-in: busy (tx_finish low) for lowlen cycles after each pulse it receives
    always @(posedge clk)
        if (next_data || new_image)
            low_cnt <= no_low ? 0 : (lowlen == 0 ? int'($urandom_range(5, 1)) : lowlen);
        else if (low_cnt > 0)
            low_cnt <= low_cnt - 1;

    assign tx_finish = !hold_low && low_cnt == 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            k_rd = 0;
            k_nd = 0;
        end else begin
            if (new_image) begin
                k_rd = 0;
                k_nd = 0;
                tot_ni++;
            end
            if (new_column) tot_nc++;
            if (frame_ack) tot_ack++;
            if (new_image || new_column || next_data || frame_ack)
                chk("pulse_exclusive", $countones({new_image, new_column, next_data, frame_ack}), 1);
            if (rd_en) begin
                chk("rd_addr", rd_addr, k_rd);
                k_rd++;
            end
            if (next_data) begin
                chk("data_out", data_out, exp_data(k_nd));
                chk("extra_bit", extra_bit, (k_nd % BPC) == BPC - 1);
                k_nd++;
                tot_nd++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_valid = 1'b0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = '0;
    endtask

    task automatic finish_frame(input vec_t v, input int s_nd, input int s_nc, input int s_ni, input int s_ack);
        int cyc;
        cyc = 0;
        while (tot_ack == s_ack && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tot_nd - s_nd >= v.drop_at) frame_valid = 1'b0;
        end
        chk("frame_done", cyc < 20000, 1);
        chk("next_data_count", tot_nd - s_nd, v.exp_nd);
        chk("new_column_count", tot_nc - s_nc, v.exp_nc);
        chk("new_image_count", tot_ni - s_ni, v.exp_ni);
        chk("frame_ack_count", tot_ack - s_ack, v.exp_ack);
        chk("addr_span", k_rd, NBYTES);
        exp_fc = exp_fc + 16'd1;
        chk("frame_count", frame_count, exp_fc);
        repeat (4) @(posedge clk);
        #1;
`ifdef MATRIX_SEQ_REPEAT_EN
        chk("after_frame_busy", busy, 1);
        chk("after_frame_replay", tot_ni - s_ni, 2);
        do_reset();
`else
        chk("after_frame_busy", busy, 0);
        chk("after_frame_idle", tot_ni - s_ni, 1);
`endif
    endtask

    task automatic run_frame(input vec_t v);
        int s_nd, s_nc, s_ni, s_ack;
        s_nd = tot_nd;
        s_nc = tot_nc;
        s_ni = tot_ni;
        s_ack = tot_ack;
        lowlen = v.lowlen;
        @(negedge clk);
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("new_image_latency", new_image, 1);
        finish_frame(v, s_nd, s_nc, s_ni, s_ack);
    endtask

    initial begin
        int s_nd, s_nc, s_ni, s_ack, lat, cyc;
        vecs[0] = '{4, 0, NBYTES, COLS - 1, 1, 1};
        vecs[1] = '{0, 0, NBYTES, COLS - 1, 1, 1};
        vecs[2] = '{0, 100, NBYTES, COLS - 1, 1, 1};
        vecs[3] = '{1, 383, NBYTES, COLS - 1, 1, 1};

        repeat (3) @(negedge clk);
        chk("reset_state", all_outs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // tx_finish held low: nothing issued until it rises, then FETCH, LATCH, ISSUE
        hold_low = 1'b1;
        lowlen = 4;
        s_nd = tot_nd; s_nc = tot_nc; s_ni = tot_ni; s_ack = tot_ack;
        @(negedge clk);
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("hold_low_no_next_data", tot_nd - s_nd, 0);
        chk("hold_low_busy", busy, 1);
        @(negedge clk);
        hold_low = 1'b0;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (next_data) begin
                lat = i;
                break;
            end
        end
        chk("next_data_latency", lat, 3);
        finish_frame(vecs[0], s_nd, s_nc, s_ni, s_ack);

        // reset in the middle of a frame
        lowlen = 2;
        s_nd = tot_nd; s_ack = tot_ack;
        @(negedge clk);
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        cyc = 0;
        while (tot_nd - s_nd < 100 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("reach_byte_100", cyc < 5000, 1);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("reset_no_frame_ack", tot_ack - s_ack, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_addr", rd_addr, 0);
        run_frame(vecs[0]);

        // tx_finish never drops: stalls in WAIT_ACC after the first byte
        no_low = 1'b1;
        s_nd = tot_nd; s_ack = tot_ack;
        @(negedge clk);
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("stall_next_data", tot_nd - s_nd, 1);
        chk("stall_busy", busy, 1);
        chk("stall_no_ack", tot_ack - s_ack, 0);
        no_low = 1'b0;
        do_reset();

        // frame_count wrap
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        exp_fc = 16'hFFFF;
        run_frame(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
